// File: rtl/program_loader.sv
// Byte-stream program loader: parses a counted stream of 19-bit words and writes
// them to instruction memory at 3-byte strides, holding the CPU until the checksum verifies.
module program_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [18:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, B2, B1, B0, WRITE, CHK, DONE, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] words_q, words_d;
  logic [15:0] addr_q, addr_d;
  logic [18:0] word_q, word_d;
  logic [7:0]  xor_q, xor_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        take;
  logic [15:0] cnt_full;
  logic [15:0] words_inc;

  assign cnt_full  = {cnt_q[15:8], rx_data};
  assign words_inc = words_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    words_d  = words_q;
    addr_d   = addr_q;
    word_d   = word_q;
    xor_d    = xor_q;
    rx_ready = 1'b0;
    imem_we  = 1'b0;

    case (state_q)
      IDLE, CNT_HI, CNT_LO, B2, B1, B0, CHK: rx_ready = 1'b1;
      default:                              rx_ready = 1'b0;
    endcase
    take = rx_valid && rx_ready;

    case (state_q)
      IDLE: begin
        if (take && rx_data == 8'hA5) begin
          state_d = CNT_HI;
          words_d = 16'd0;
          addr_d  = 16'd0;
          xor_d   = 8'd0;
        end
      end
      CNT_HI: begin
        if (take) begin
          cnt_d   = {rx_data, 8'h00};
          xor_d   = xor_q ^ rx_data;
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (take) begin
          cnt_d = cnt_full;
          xor_d = xor_q ^ rx_data;
          // 0x5555 words is the most that fits below the top of the 16-bit address space
          if (cnt_full > 16'h5555)    state_d = ERR;
          else if (cnt_full == 16'd0) state_d = CHK;
          else                        state_d = B2;
        end
      end
      B2: begin
        if (take) begin
          xor_d = xor_q ^ rx_data;
          if (rx_data[7:3] != 5'd0) begin
            state_d = ERR;
          end else begin
            word_d  = {rx_data[2:0], 16'h0000};
            state_d = B1;
          end
        end
      end
      B1: begin
        if (take) begin
          xor_d         = xor_q ^ rx_data;
          word_d[15:8]  = rx_data;
          state_d       = B0;
        end
      end
      B0: begin
        if (take) begin
          xor_d        = xor_q ^ rx_data;
          word_d[7:0]  = rx_data;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        imem_we = 1'b1;
        words_d = words_inc;
        addr_d  = addr_q + 16'd3;
        state_d = (words_inc == cnt_q) ? CHK : B2;
      end
      CHK: begin
        if (take) state_d = (rx_data == xor_q) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (restart) begin
          state_d = IDLE;
          words_d = 16'd0;
          addr_d  = 16'd0;
          xor_d   = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      words_q <= 16'd0;
      addr_q  <= 16'd0;
      word_q  <= 19'd0;
      xor_q   <= 8'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign imem_addr    = addr_q;
  assign imem_wdata   = word_q;
  assign words_loaded = words_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_hold     = (state_q != DONE);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed streams plus randomized loads
// compared against a stream-level reference model of the expected writes.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        restart;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [18:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int vectors = 0;
  int miscompares = 0;
  bit noisy = 1'b0;

  logic [7:0]  stream[$];
  logic [18:0] exp_words[$];
  logic [15:0] got_addr[$];
  logic [18:0] got_data[$];

  program_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Each WRITE lasts one cycle, so one negedge sample captures every write once.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  // Reference stream: header, 16-bit count, 3 bytes per word MSB first, XOR of all post-header bytes.
  task automatic build_stream(input bit corrupt);
    logic [7:0]  chk;
    logic [15:0] n;
    stream.delete();
    n = 16'(exp_words.size());
    stream.push_back(8'hA5);
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    foreach (exp_words[k]) begin
      stream.push_back({5'd0, exp_words[k][18:16]});
      stream.push_back(exp_words[k][15:8]);
      stream.push_back(exp_words[k][7:0]);
    end
    chk = 8'd0;
    for (int i = 1; i < stream.size(); i++) chk = chk ^ stream[i];
    stream.push_back(corrupt ? (chk ^ 8'h01) : chk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    if ($urandom_range(0, 3) == 0) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      restart  = noisy && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    restart  = noisy && ($urandom_range(0, 2) == 0);
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL rx_ready_timeout: rx_ready=%b, required 1 within 50 cycles", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic send_stream();
    foreach (stream[i]) send_byte(stream[i]);
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done === 1'b1 || error === 1'b1) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL end_timeout: done=%b error=%b, required one of them within 50 cycles", done, error);
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    vectors++;
    if (done !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b1 || words_loaded !== 16'd0 || cpu_hold !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart: done=%b error=%b rx_ready=%b words=%0d hold=%b, required 0 0 1 0 1",
               done, error, rx_ready, words_loaded, cpu_hold);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    restart  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    vectors++;
    if (imem_we !== 1'b0 || imem_addr !== 16'd0 || imem_wdata !== 19'd0 || words_loaded !== 16'd0 ||
        done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_state: we=%b addr=%h wdata=%h words=%0d done=%b err=%b hold=%b rdy=%b, required 0 0 0 0 0 0 1 1",
               imem_we, imem_addr, imem_wdata, words_loaded, done, error, cpu_hold, rx_ready);
    end
    restart  = 1'b0;
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed_two_words();
    got_addr.delete(); got_data.delete();
    stream = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07, 8'h62};
    send_stream();
    wait_end();
    vectors++;
    if (got_addr.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL two_words_count: writes=%0d, required 2", got_addr.size());
    end else begin
      vectors++;
      if (got_addr[0] !== 16'h0000 || got_data[0] !== 19'h12345 || got_addr[1] !== 16'h0003 || got_data[1] !== 19'h00007) begin
        miscompares++;
        $display("[TB] FAIL two_words_data: (%h,%h) (%h,%h), required (0000,12345) (0003,00007)",
                 got_addr[0], got_data[0], got_addr[1], got_data[1]);
      end
    end
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || words_loaded !== 16'd2 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL two_words_final: done=%b err=%b hold=%b words=%0d rdy=%b, required 1 0 0 2 0",
               done, error, cpu_hold, words_loaded, rx_ready);
    end
    pulse_restart();
  endtask

  task automatic test_zero_count();
    got_addr.delete(); got_data.delete();
    stream = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_stream();
    wait_end();
    vectors++;
    if (got_addr.size() != 0 || done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL zero_count: writes=%0d done=%b err=%b words=%0d, required 0 1 0 0",
               got_addr.size(), done, error, words_loaded);
    end
    pulse_restart();
  endtask

  task automatic test_leading_garbage();
    got_addr.delete(); got_data.delete();
    stream = '{8'h5A, 8'h11, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    send_stream();
    wait_end();
    vectors++;
    if (got_addr.size() != 1 || done !== 1'b1 || words_loaded !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL garbage_final: writes=%0d done=%b words=%0d, required 1 1 1", got_addr.size(), done, words_loaded);
    end else begin
      vectors++;
      if (got_addr[0] !== 16'h0000 || got_data[0] !== 19'h00001) begin
        miscompares++;
        $display("[TB] FAIL garbage_write: (%h,%h), required (0000,00001)", got_addr[0], got_data[0]);
      end
    end
    pulse_restart();
  endtask

  task automatic test_bad_b2();
    got_addr.delete(); got_data.delete();
    stream = '{8'hA5, 8'h00, 8'h01, 8'h08};
    send_stream();
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    vectors++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b0 || got_addr.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL bad_b2: err=%b done=%b hold=%b rdy=%b writes=%0d, required 1 0 1 0 0",
               error, done, cpu_hold, rx_ready, got_addr.size());
    end
    pulse_restart();
  endtask

  task automatic test_count_limits();
    got_addr.delete(); got_data.delete();
    stream = '{8'hA5, 8'h55, 8'h56};
    send_stream();
    vectors++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || got_addr.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL count_5556: err=%b rdy=%b writes=%0d, required 1 0 0", error, rx_ready, got_addr.size());
    end
    pulse_restart();
    stream = '{8'hA5, 8'h55, 8'h55};
    send_stream();
    vectors++;
    if (error !== 1'b0 || rx_ready !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL count_5555: err=%b rdy=%b done=%b, required 0 1 0", error, rx_ready, done);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bad_checksum();
    int n = $urandom_range(1, 5);
    got_addr.delete(); got_data.delete();
    exp_words.delete();
    for (int k = 0; k < n; k++) exp_words.push_back(19'($urandom));
    build_stream(1'b1);
    send_stream();
    wait_end();
    vectors++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 16'(n) || got_addr.size() != n) begin
      miscompares++;
      $display("[TB] FAIL bad_checksum: err=%b done=%b hold=%b words=%0d writes=%0d, required 1 0 1 %0d %0d",
               error, done, cpu_hold, words_loaded, got_addr.size(), n, n);
    end
    pulse_restart();
  endtask

  task automatic test_back_to_back_random();
    noisy = 1'b1;
    for (int it = 0; it < 8; it++) begin
      int n = $urandom_range(1, 10);
      got_addr.delete(); got_data.delete();
      exp_words.delete();
      for (int k = 0; k < n; k++) exp_words.push_back(19'($urandom));
      build_stream(1'b0);
      send_stream();
      wait_end();
      vectors++;
      if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || words_loaded !== 16'(n) || got_addr.size() != n) begin
        miscompares++;
        $display("[TB] FAIL random_final[%0d]: done=%b err=%b hold=%b words=%0d writes=%0d, required 1 0 0 %0d %0d",
                 it, done, error, cpu_hold, words_loaded, got_addr.size(), n, n);
      end
      for (int k = 0; k < n && k < got_addr.size(); k++) begin
        vectors++;
        if (got_addr[k] !== 16'(3 * k) || got_data[k] !== exp_words[k]) begin
          miscompares++;
          $display("[TB] FAIL random_write[%0d][%0d]: (%h,%h), required (%h,%h)",
                   it, k, got_addr[k], got_data[k], 16'(3 * k), exp_words[k]);
        end
      end
      pulse_restart();
    end
    noisy = 1'b0;
  endtask

  task automatic test_reset_midword();
    got_addr.delete(); got_data.delete();
    stream = '{8'hA5, 8'h00, 8'h02, 8'h04, 8'hBE, 8'hEF, 8'h02};
    send_stream();
    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    @(negedge clk);
    rx_valid = 1'b0;
    vectors++;
    if (imem_we !== 1'b0 || imem_addr !== 16'd0 || imem_wdata !== 19'd0 || words_loaded !== 16'd0 ||
        done !== 1'b0 || error !== 1'b0 || cpu_hold !== 1'b1 || rx_ready !== 1'b1 || got_addr.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL midword_reset: we=%b addr=%h wdata=%h words=%0d done=%b err=%b hold=%b rdy=%b writes=%0d, required 0 0 0 0 0 0 1 1 1",
               imem_we, imem_addr, imem_wdata, words_loaded, done, error, cpu_hold, rx_ready, got_addr.size());
    end
    reset = 1'b1;
    @(negedge clk);
    got_addr.delete(); got_data.delete();
    exp_words = '{19'h7ABCD, 19'h00042};
    build_stream(1'b0);
    send_stream();
    wait_end();
    vectors++;
    if (done !== 1'b1 || got_addr.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL midword_reload: done=%b writes=%0d, required 1 2", done, got_addr.size());
    end else begin
      vectors++;
      if (got_addr[0] !== 16'h0000 || got_data[0] !== 19'h7ABCD || got_addr[1] !== 16'h0003 || got_data[1] !== 19'h00042) begin
        miscompares++;
        $display("[TB] FAIL midword_reload_data: (%h,%h) (%h,%h), required (0000,7abcd) (0003,00042)",
                 got_addr[0], got_data[0], got_addr[1], got_data[1]);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    restart  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_directed_two_words();
    test_zero_count();
    test_leading_garbage();
    test_bad_b2();
    test_count_limits();
    test_bad_checksum();
    test_back_to_back_random();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
